// File: rtl/spi_frame_router.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_router
// Purpose  : Assembles SPI byte frames (opcode, address, value) into bus
//            commands. Each command goes to exactly one of NUM_CORES core
//            interfaces, chosen by equal-sized address windows. Burst reads
//            and writes auto-increment the address. Read data is returned
//            MSB-first on the SPI tx byte.
// Ports    : clk_i / rst_ni          system clock, async active-low reset
//            spi_cs_i                SPI chip select (async, active low)
//            spi_rx_valid_i/_byte_i  received byte strobe and data
//            spi_tx_byte_o           byte shifted out during next SPI byte
//            instruction_o           latched opcode
//            address_o               current word address
//            value_o                 write value
//            cmd_valid_o             one-cycle command strobe
//            core_sel_o              one-hot target core, qualifies strobe
//            result_i                per-core results, core k at [k*DW +: DW]
//            err_o                   sticky frame error
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_router #(
    parameter int ADDR_BYTES = 3,
    parameter int DATA_BYTES = 4,
    parameter int NUM_CORES  = 2,
    parameter int CORE_SPAN  = 16,
    parameter int RESULT_LAT = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              spi_cs_i,
    input  logic                              spi_rx_valid_i,
    input  logic [7:0]                        spi_rx_byte_i,
    output logic [7:0]                        spi_tx_byte_o,
    output logic [7:0]                        instruction_o,
    output logic [8*ADDR_BYTES-1:0]           address_o,
    output logic [8*DATA_BYTES-1:0]           value_o,
    output logic                              cmd_valid_o,
    output logic [NUM_CORES-1:0]              core_sel_o,
    input  logic [NUM_CORES*8*DATA_BYTES-1:0] result_i,
    output logic                              err_o
);

    localparam int AW     = 8 * ADDR_BYTES;
    localparam int DW     = 8 * DATA_BYTES;
    localparam int MAXB   = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int CW     = $clog2(MAXB + 1);
    localparam int SW     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    localparam logic [7:0] c_OP_WRITE = 8'h01;
    localparam logic [7:0] c_OP_READ  = 8'h02;
    localparam logic [7:0] c_TX_ERR   = 8'hEE;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ADDR    = 3'd1;
    localparam logic [2:0] c_DATA    = 3'd2;
    localparam logic [2:0] c_RESP    = 3'd3;
    localparam logic [2:0] c_DISCARD = 3'd4;

    localparam logic [CW-1:0] c_LAST_ADDR = CW'(ADDR_BYTES - 1);
    localparam logic [CW-1:0] c_LAST_DATA = CW'(DATA_BYTES - 1);

    // ------------------------------------------------------------------
    // Window decode helpers
    // ------------------------------------------------------------------
    function automatic logic [NUM_CORES-1:0] f_decode(input logic [AW-1:0] addr);
        logic [NUM_CORES-1:0] sel;
        logic [63:0]          a64;
        sel = '0;
        a64 = 64'(addr);
        for (int k = 0; k < NUM_CORES; k++) begin
            if ((a64 >= 64'(k * CORE_SPAN)) && (a64 < 64'((k + 1) * CORE_SPAN))) begin
                sel[k] = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [SW-1:0] f_index(input logic [NUM_CORES-1:0] onehot);
        logic [SW-1:0] idx;
        idx = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (onehot[k]) begin
                idx = SW'(k);
            end
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [1:0]            r_cs_sync;
    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [CW-1:0]         r_byte_cnt;
    logic [DW-1:0]         r_wdata_sh;
    logic [DW-1:0]         r_rd_sh;
    logic [RESULT_LAT-1:0] r_cap_pipe;
    logic [SW-1:0]         r_sel_idx;

    logic                  w_cs_high;
    logic                  w_rx;
    logic                  w_op_valid;
    logic [AW-1:0]         w_addr_shift;
    logic [AW-1:0]         w_addr_inc;
    logic [AW-1:0]         w_dec_addr;
    logic [NUM_CORES-1:0]  w_dec_sel;
    logic                  w_in_range;
    logic [DW-1:0]         w_wdata_shift;
    logic                  w_last_addr;
    logic                  w_last_data;
    logic                  w_rd_strobe;
    logic                  w_capture;
    logic [DW-1:0]         w_results [NUM_CORES];

    generate
        for (genvar k = 0; k < NUM_CORES; k++) begin : g_slice
            assign w_results[k] = result_i[k*DW +: DW];
        end
    endgenerate

    // Frame end is the synchronised chip select; it also gates rx so a byte
    // landing in the same cycle as cs-high is dropped.
    assign w_cs_high     = r_cs_sync[1];
    assign w_rx          = spi_rx_valid_i && !w_cs_high;
    assign w_op_valid    = (spi_rx_byte_i == c_OP_WRITE) || (spi_rx_byte_i == c_OP_READ);
    assign w_addr_shift  = AW'({address_o, spi_rx_byte_i});
    assign w_addr_inc    = address_o + AW'(1);
    assign w_wdata_shift = DW'({r_wdata_sh, spi_rx_byte_i});
    assign w_last_addr   = (r_byte_cnt == c_LAST_ADDR);
    assign w_last_data   = (r_byte_cnt == c_LAST_DATA);

    // The address to decode depends on where the word boundary falls:
    // the freshly shifted address at the end of ADDR, the current address
    // in a write burst (already incremented after the previous strobe), and
    // the next address in a read burst.
    always_comb begin
        w_dec_addr = address_o;
        case (r_state)
            c_ADDR:  w_dec_addr = w_addr_shift;
            c_RESP:  w_dec_addr = w_addr_inc;
            default: w_dec_addr = address_o;
        endcase
    end

    assign w_dec_sel  = f_decode(w_dec_addr);
    assign w_in_range = |w_dec_sel;

    // Read strobes feed a delay line whose tail marks the cycle result_i is
    // valid for the selected core.
    assign w_rd_strobe = cmd_valid_o && (r_state == c_RESP);
    assign w_capture   = r_cap_pipe[RESULT_LAT-1] && (r_state == c_RESP);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_rx) begin
                    w_state_nxt = w_op_valid ? c_ADDR : c_DISCARD;
                end
            end
            c_ADDR: begin
                if (w_rx && w_last_addr) begin
                    if (!w_in_range) begin
                        w_state_nxt = c_DISCARD;
                    end else if (instruction_o == c_OP_WRITE) begin
                        w_state_nxt = c_DATA;
                    end else begin
                        w_state_nxt = c_RESP;
                    end
                end
            end
            c_DATA, c_RESP: begin
                if (w_rx && w_last_data && !w_in_range) begin
                    w_state_nxt = c_DISCARD;
                end
            end
            c_DISCARD: w_state_nxt = c_DISCARD;
            default:   w_state_nxt = c_IDLE;
        endcase
        if (w_cs_high) begin
            w_state_nxt = c_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cs_sync     <= 2'b11;
            r_byte_cnt    <= '0;
            r_wdata_sh    <= '0;
            r_rd_sh       <= '0;
            r_cap_pipe    <= '0;
            r_sel_idx     <= '0;
            instruction_o <= '0;
            address_o     <= '0;
            value_o       <= '0;
            cmd_valid_o   <= 1'b0;
            core_sel_o    <= '0;
            err_o         <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], spi_cs_i};
            cmd_valid_o <= 1'b0;
            core_sel_o  <= '0;
            r_cap_pipe  <= RESULT_LAT'({r_cap_pipe, w_rd_strobe});

            if (w_cs_high) begin
                // Drop any partial word; address, value and error are kept.
                r_byte_cnt <= '0;
                r_wdata_sh <= '0;
                r_rd_sh    <= '0;
                r_cap_pipe <= '0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_rx) begin
                            instruction_o <= spi_rx_byte_i;
                            err_o         <= !w_op_valid;
                            r_byte_cnt    <= '0;
                        end
                    end

                    c_ADDR: begin
                        if (w_rx) begin
                            address_o <= w_addr_shift;
                            if (w_last_addr) begin
                                r_byte_cnt <= '0;
                                r_wdata_sh <= '0;
                                if (!w_in_range) begin
                                    err_o <= 1'b1;
                                end else if (instruction_o == c_OP_READ) begin
                                    cmd_valid_o <= 1'b1;
                                    core_sel_o  <= w_dec_sel;
                                    r_sel_idx   <= f_index(w_dec_sel);
                                    r_rd_sh     <= '0;
                                end
                            end else begin
                                r_byte_cnt <= r_byte_cnt + CW'(1);
                            end
                        end
                    end

                    c_DATA: begin
                        // Advance to the next word address once the strobe
                        // has been seen with the old address.
                        if (cmd_valid_o) begin
                            address_o <= w_addr_inc;
                        end
                        if (w_rx) begin
                            if (w_last_data) begin
                                r_byte_cnt <= '0;
                                r_wdata_sh <= '0;
                                if (w_in_range) begin
                                    value_o     <= w_wdata_shift;
                                    cmd_valid_o <= 1'b1;
                                    core_sel_o  <= w_dec_sel;
                                end else begin
                                    err_o <= 1'b1;
                                end
                            end else begin
                                r_byte_cnt <= r_byte_cnt + CW'(1);
                                r_wdata_sh <= w_wdata_shift;
                            end
                        end
                    end

                    c_RESP: begin
                        if (w_rx) begin
                            // Each dummy byte exposes the next result byte.
                            r_rd_sh <= r_rd_sh << 8;
                            if (w_last_data) begin
                                r_byte_cnt <= '0;
                                address_o  <= w_addr_inc;
                                if (w_in_range) begin
                                    cmd_valid_o <= 1'b1;
                                    core_sel_o  <= w_dec_sel;
                                    r_sel_idx   <= f_index(w_dec_sel);
                                end else begin
                                    err_o <= 1'b1;
                                end
                            end else begin
                                r_byte_cnt <= r_byte_cnt + CW'(1);
                            end
                        end
                        if (w_capture) begin
                            r_rd_sh <= w_results[r_sel_idx];
                        end
                    end

                    default: begin
                        // DISCARD: bytes are ignored until the frame ends.
                    end
                endcase
            end
        end
    end

    always_comb begin
        spi_tx_byte_o = 8'h00;
        case (r_state)
            c_RESP:    spi_tx_byte_o = r_rd_sh[DW-1 -: 8];
            c_DISCARD: spi_tx_byte_o = c_TX_ERR;
            default:   spi_tx_byte_o = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_frame_router
// Purpose  : Directed self-checking bench for spi_frame_router with the
//            default parameters (3 address bytes, 4 data bytes, 2 cores of
//            16 addresses, result latency 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_frame_router;

    logic        clk;
    logic        rst_n;
    logic        spi_cs;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic [7:0]  instruction;
    logic [23:0] address;
    logic [31:0] value;
    logic        cmd_valid;
    logic [1:0]  core_sel;
    logic [63:0] result;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    int          n_strobes = 0;
    logic [23:0] log_addr [0:63];
    logic [31:0] log_val  [0:63];
    logic [1:0]  log_sel  [0:63];

    int base;

    spi_frame_router dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .spi_cs_i       (spi_cs),
        .spi_rx_valid_i (rx_valid),
        .spi_rx_byte_i  (rx_byte),
        .spi_tx_byte_o  (tx_byte),
        .instruction_o  (instruction),
        .address_o      (address),
        .value_o        (value),
        .cmd_valid_o    (cmd_valid),
        .core_sel_o     (core_sel),
        .result_i       (result),
        .err_o          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid && (n_strobes < 64)) begin
            log_addr[n_strobes] = address;
            log_val[n_strobes]  = value;
            log_sel[n_strobes]  = core_sel;
            n_strobes = n_strobes + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    task automatic start_frame();
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_frame();
        @(negedge clk);
        spi_cs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        spi_cs   = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        result   = {32'h12345678, 32'hCAFEF00D};

        repeat (3) @(negedge clk);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_core_sel", core_sel, 2'b00);
        check("rst_address", address, 24'h000000);
        check("rst_value", value, 32'h00000000);
        check("rst_instr", instruction, 8'h00);
        check("rst_err", err, 1'b0);
        check("rst_tx", tx_byte, 8'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        base = n_strobes;
        start_frame();
        send_byte(8'h01);
        check("wr_tx_addr_phase", tx_byte, 8'h00);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        check("wr_no_early_strobe", n_strobes - base, 0);
        send_byte(8'hEF);
        check("wr_strobe_count", n_strobes - base, 1);
        check("wr_addr", log_addr[base], 24'h000005);
        check("wr_value", log_val[base], 32'hDEADBEEF);
        check("wr_sel", log_sel[base], 2'b01);
        check("wr_err", err, 1'b0);
        check("wr_instr", instruction, 8'h01);
        end_frame();
        check("wr_addr_hold", address, 24'h000006);
        check("wr_value_hold", value, 32'hDEADBEEF);

        base = n_strobes;
        start_frame();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h12);
        check("rd_strobe_count", n_strobes - base, 1);
        check("rd_addr", log_addr[base], 24'h000012);
        check("rd_sel", log_sel[base], 2'b10);
        check("rd_tx0", tx_byte, 8'h12);
        send_byte(8'h00);
        check("rd_tx1", tx_byte, 8'h34);
        send_byte(8'h00);
        check("rd_tx2", tx_byte, 8'h56);
        send_byte(8'h00);
        check("rd_tx3", tx_byte, 8'h78);
        send_byte(8'h00);
        check("rd_burst_count", n_strobes - base, 2);
        check("rd_burst_addr", log_addr[base+1], 24'h000013);
        check("rd_burst_sel", log_sel[base+1], 2'b10);
        check("rd_burst_tx0", tx_byte, 8'h12);
        end_frame();
        check("rd_idle_tx", tx_byte, 8'h00);

        base = n_strobes;
        start_frame();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0F);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        check("bw_count", n_strobes - base, 2);
        check("bw_addr0", log_addr[base], 24'h00000F);
        check("bw_sel0", log_sel[base], 2'b01);
        check("bw_val0", log_val[base], 32'h11223344);
        check("bw_addr1", log_addr[base+1], 24'h000010);
        check("bw_sel1", log_sel[base+1], 2'b10);
        check("bw_val1", log_val[base+1], 32'h55667788);
        check("bw_err", err, 1'b0);
        end_frame();

        base = n_strobes;
        start_frame();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        check("oor_no_strobe", n_strobes - base, 0);
        check("oor_err", err, 1'b1);
        check("oor_tx", tx_byte, 8'hEE);
        send_byte(8'h00);
        check("oor_tx_dummy", tx_byte, 8'hEE);
        end_frame();
        check("oor_err_hold", err, 1'b1);

        start_frame();
        send_byte(8'h01);
        check("clr_err", err, 1'b0);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB);
        end_frame();
        check("abort_no_strobe", n_strobes - base, 0);
        check("abort_tx", tx_byte, 8'h00);

        start_frame();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        check("after_abort_no_early", n_strobes - base, 0);
        send_byte(8'h33); send_byte(8'h44);
        check("after_abort_count", n_strobes - base, 1);
        check("after_abort_addr", log_addr[base], 24'h000002);
        check("after_abort_val", log_val[base], 32'h11223344);
        end_frame();

        base = n_strobes;
        start_frame();
        send_byte(8'h7F);
        check("inv_err", err, 1'b1);
        check("inv_tx", tx_byte, 8'hEE);
        check("inv_instr", instruction, 8'h7F);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        check("inv_no_strobe", n_strobes - base, 0);
        end_frame();
        check("inv_idle_tx", tx_byte, 8'h00);

        base = n_strobes;
        start_frame();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        @(negedge clk);
        spi_cs = 1'b1;
        repeat (2) @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = 8'h04;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        repeat (4) @(negedge clk);
        check("coinc_no_strobe", n_strobes - base, 0);
        check("coinc_value_hold", value, 32'h11223344);

        start_frame();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h12);
        check("mid_rd_tx", tx_byte, 8'h12);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tx", tx_byte, 8'h00);
        check("arst_addr", address, 24'h000000);
        check("arst_instr", instruction, 8'h00);
        check("arst_value", value, 32'h00000000);
        check("arst_err", err, 1'b0);
        check("arst_sel", core_sel, 2'b00);
        check("arst_cmd_valid", cmd_valid, 1'b0);
        repeat (2) @(negedge clk);
        spi_cs = 1'b1;
        rst_n  = 1'b1;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
